// File: rtl/uart_bus_master.sv
// uart_bus_master: UART byte-command bridge acting as a native memory bus initiator.
// Optional bus timeout is compiled in by defining UART_BUS_MASTER_TIMEOUT_EN.
`timescale 1ns/1ps
module uart_bus_master #(
   parameter int TIMEOUT = 1024
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic        mem_valid,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wstrb,
   input  logic        mem_ready,
   input  logic [31:0] mem_rdata,
   output logic        busy,
   output logic        err
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADDR,
      S_DATA,
      S_BUS,
      S_RESP
   } state_t;

   state_t      r_state;
   state_t      w_next;
   logic [1:0]  r_cnt;
   logic        r_wr;
   logic [31:0] r_addr;
   logic [23:0] r_data;
   logic [31:0] r_mem_addr;
   logic [31:0] r_mem_wdata;
   logic [3:0]  r_mem_wstrb;
   logic [31:0] r_resp;
   logic [1:0]  r_rcnt;
   logic        r_err;

   logic        w_op_w;
   logic        w_op_r;
   logic        w_tx_fire;
   logic        w_tout;
   logic [31:0] w_addr_nxt;
   logic [31:0] w_data_nxt;

   assign w_op_w     = (rx_data == 8'h57);
   assign w_op_r     = (rx_data == 8'h52);
   assign w_tx_fire  = tx_valid && tx_ready;
   assign w_addr_nxt = {r_addr[23:0], rx_data};
   assign w_data_nxt = {r_data, rx_data};

`ifdef UART_BUS_MASTER_TIMEOUT_EN
   logic [15:0] r_tcnt;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_tcnt <= '0;
      end else if (r_state == S_BUS) begin
         r_tcnt <= r_tcnt + 16'd1;
      end else begin
         r_tcnt <= '0;
      end
   end

   // A ready in the expiry cycle wins over the timeout
   assign w_tout = (r_tcnt == 16'(TIMEOUT - 1)) && !mem_ready;
`else
   logic w_unused_timeout;
   assign w_unused_timeout = (TIMEOUT != 0);
   assign w_tout = 1'b0;
`endif

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE: begin
            if (rx_valid) begin
               w_next = (w_op_w || w_op_r) ? S_ADDR : S_RESP;
            end
         end
         S_ADDR: begin
            if (rx_valid && (r_cnt == 2'd3)) begin
               w_next = r_wr ? S_DATA : S_BUS;
            end
         end
         S_DATA: begin
            if (rx_valid && (r_cnt == 2'd3)) begin
               w_next = S_BUS;
            end
         end
         S_BUS: begin
            if (mem_ready || w_tout) begin
               w_next = S_RESP;
            end
         end
         S_RESP: begin
            if (w_tx_fire && (r_rcnt == 2'd0)) begin
               w_next = S_IDLE;
            end
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_comb begin
      mem_valid = (r_state == S_BUS);
      tx_valid  = (r_state == S_RESP);
      busy      = (r_state != S_IDLE);
   end

   assign tx_data   = r_resp[31:24];
   assign mem_addr  = r_mem_addr;
   assign mem_wdata = r_mem_wdata;
   assign mem_wstrb = r_mem_wstrb;
   assign err       = r_err;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_cnt       <= '0;
         r_wr        <= 1'b0;
         r_addr      <= '0;
         r_data      <= '0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_mem_wstrb <= '0;
         r_resp      <= '0;
         r_rcnt      <= '0;
         r_err       <= 1'b0;
      end else begin
         r_err <= 1'b0;
         unique case (r_state)
            S_IDLE: begin
               r_cnt <= '0;
               if (rx_valid) begin
                  r_wr <= w_op_w;
                  if (!(w_op_w || w_op_r)) begin
                     r_resp <= {8'h3F, 24'h0};
                     r_rcnt <= 2'd0;
                     r_err  <= 1'b1;
                  end
               end
            end
            S_ADDR: begin
               if (rx_valid) begin
                  r_addr <= w_addr_nxt;
                  r_cnt  <= r_cnt + 2'd1;
                  if ((r_cnt == 2'd3) && !r_wr) begin
                     r_mem_addr  <= {w_addr_nxt[31:2], 2'b00};
                     r_mem_wstrb <= 4'h0;
                  end
               end
            end
            S_DATA: begin
               if (rx_valid) begin
                  r_data <= w_data_nxt[23:0];
                  r_cnt  <= r_cnt + 2'd1;
                  if (r_cnt == 2'd3) begin
                     r_mem_addr  <= {r_addr[31:2], 2'b00};
                     r_mem_wdata <= w_data_nxt;
                     r_mem_wstrb <= 4'hF;
                  end
               end
            end
            S_BUS: begin
               if (mem_ready) begin
                  r_resp <= r_wr ? {8'h4B, 24'h0} : mem_rdata;
                  r_rcnt <= r_wr ? 2'd0 : 2'd3;
               end else if (w_tout) begin
                  r_resp <= {8'h54, 24'h0};
                  r_rcnt <= 2'd0;
                  r_err  <= 1'b1;
               end
            end
            S_RESP: begin
               if (w_tx_fire) begin
                  r_resp <= {r_resp[23:0], 8'h00};
                  r_rcnt <= r_rcnt - 2'd1;
               end
            end
            default: begin
               r_cnt <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_bus_master.sv
// tb_uart_bus_master: scoreboard bench for the UART bus master bridge.
// Define UART_BUS_MASTER_TIMEOUT_EN to exercise the timeout build.
`timescale 1ns/1ps
module tb_uart_bus_master;

`ifdef UART_BUS_MASTER_TIMEOUT_EN
   localparam int TO = 16;
`else
   localparam int TO = 1024;
`endif

   logic        clk = 1'b0;
   logic        resetn;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic        mem_valid;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic        mem_ready;
   logic [31:0] mem_rdata;
   logic        busy;
   logic        err;

   uart_bus_master #(.TIMEOUT(TO)) dut (
      .clk       (clk),
      .resetn    (resetn),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .tx_data   (tx_data),
      .tx_valid  (tx_valid),
      .tx_ready  (tx_ready),
      .mem_valid (mem_valid),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_wstrb (mem_wstrb),
      .mem_ready (mem_ready),
      .mem_rdata (mem_rdata),
      .busy      (busy),
      .err       (err)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0] exp_q[$];
   logic [7:0] obs_q[$];

   int          wait_cfg  = 0;
   bit          resp_en   = 1'b1;
   bit          tx_toggle = 1'b0;
   logic [31:0] rd_word   = '0;
   int          bus_len   = 0;
   int          bus_cnt   = 0;
   int          last_len  = 0;
   int          valid_cyc = 0;
   int          unstable  = 0;
   int          err_cnt   = 0;
   logic [31:0] cap_addr;
   logic [31:0] cap_wdata;
   logic [3:0]  cap_wstrb;

   // Responder, transmitter sink and bus observer, all at the falling edge
   initial begin
      mem_ready = 1'b0;
      mem_rdata = '0;
      tx_ready  = 1'b0;
      forever begin
         @(negedge clk);
         tx_ready = tx_toggle ? ~tx_ready : 1'b1;
         if (tx_valid && tx_ready) obs_q.push_back(tx_data);
         if (err) err_cnt++;
         if (mem_valid) begin
            bus_len++;
            valid_cyc++;
            if (bus_len == 1) begin
               cap_addr  = mem_addr;
               cap_wdata = mem_wdata;
               cap_wstrb = mem_wstrb;
            end else if (mem_addr !== cap_addr || mem_wdata !== cap_wdata ||
                         mem_wstrb !== cap_wstrb) begin
               unstable++;
            end
            mem_ready = resp_en && (bus_len > wait_cfg);
            mem_rdata = rd_word;
            if (mem_ready) begin
               bus_cnt++;
               last_len = bus_len;
            end
         end else begin
            bus_len   = 0;
            mem_ready = 1'b0;
         end
      end
   end

   task automatic send_byte(input logic [7:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w);
      for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8]);
   endtask

   task automatic push_word(input logic [31:0] w);
      for (int i = 3; i >= 0; i--) exp_q.push_back(w[i*8 +: 8]);
   endtask

   task automatic wait_obs(input int n, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         #1;
         if (obs_q.size() >= n) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset;
      resetn   = 1'b0;
      rx_valid = 1'b0;
      rx_data  = '0;
      repeat (3) @(negedge clk);
      n_checks++;
      if ({mem_valid, tx_valid, busy, err} !== 4'b0) begin
         n_fail++;
         $display("FAIL reset_ctl: got %b want 0000", {mem_valid, tx_valid, busy, err});
      end
      n_checks++;
      if ({mem_addr, mem_wdata, mem_wstrb, tx_data} !== 76'd0) begin
         n_fail++;
         $display("FAIL reset_data: addr %h wdata %h wstrb %h tx %h want 0",
                  mem_addr, mem_wdata, mem_wstrb, tx_data);
      end
      resetn = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_write;
      bit ok;
      int b0;
      logic [7:0] e, a;
      wait_cfg = 0;
      b0 = bus_cnt;
      exp_q.push_back(8'h4B);
      send_byte(8'h57);
      send_word(32'h0000_0108);
      n_checks++;
      if (mem_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL wr_early_valid: got %b want 0", mem_valid);
      end
      send_word(32'hDEAD_BEEF);
      n_checks++;
      if ({mem_valid, mem_addr, mem_wdata, mem_wstrb} !== {1'b1, 32'h108, 32'hDEADBEEF, 4'hF}) begin
         n_fail++;
         $display("FAIL wr_req: got v%b a%h d%h s%h want v1 a00000108 ddeadbeef sf",
                  mem_valid, mem_addr, mem_wdata, mem_wstrb);
      end
      @(negedge clk);
      n_checks++;
      if ({mem_valid, tx_valid, tx_data} !== {1'b0, 1'b1, 8'h4B}) begin
         n_fail++;
         $display("FAIL wr_turn: got v%b tv%b tx%h want v0 tv1 tx4b", mem_valid, tx_valid, tx_data);
      end
      wait_obs(1, ok);
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL wr_resp_wait: got %0d bytes want 1", obs_q.size());
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         a = (obs_q.size() > 0) ? obs_q.pop_front() : 8'hxx;
         n_checks++;
         if (a !== e) begin
            n_fail++;
            $display("FAIL wr_tx: got %h want %h", a, e);
         end
      end
      @(posedge clk);
      #1;
      n_checks++;
      if ({tx_valid, busy} !== 2'b00) begin
         n_fail++;
         $display("FAIL wr_end: got tv%b busy%b want 00", tx_valid, busy);
      end
      n_checks++;
      if (bus_cnt - b0 !== 1 || last_len !== 1) begin
         n_fail++;
         $display("FAIL wr_tenure: got n%0d len%0d want n1 len1", bus_cnt - b0, last_len);
      end
      @(negedge clk);
   endtask

   task automatic test_read;
      bit ok;
      logic [7:0] e, a;
      wait_cfg  = 3;
      tx_toggle = 1'b1;
      rd_word   = 32'h1234_5678;
      push_word(32'h1234_5678);
      send_byte(8'h52);
      send_word(32'h0000_010B);
      n_checks++;
      if ({mem_valid, mem_addr, mem_wstrb} !== {1'b1, 32'h108, 4'h0}) begin
         n_fail++;
         $display("FAIL rd_req: got v%b a%h s%h want v1 a00000108 s0",
                  mem_valid, mem_addr, mem_wstrb);
      end
      wait_obs(4, ok);
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL rd_resp_wait: got %0d bytes want 4", obs_q.size());
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         a = (obs_q.size() > 0) ? obs_q.pop_front() : 8'hxx;
         n_checks++;
         if (a !== e) begin
            n_fail++;
            $display("FAIL rd_tx: got %h want %h", a, e);
         end
      end
      n_checks++;
      if (last_len !== 4) begin
         n_fail++;
         $display("FAIL rd_tenure: got %0d want 4", last_len);
      end
      tx_toggle = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_bad_opcode;
      bit ok;
      int b0, e0, v0;
      logic [7:0] e, a;
      wait_cfg = 0;
      b0 = bus_cnt;
      e0 = err_cnt;
      v0 = valid_cyc;
      exp_q.push_back(8'h3F);
      send_byte(8'h41);
      n_checks++;
      if ({tx_valid, tx_data, err} !== {1'b1, 8'h3F, 1'b1}) begin
         n_fail++;
         $display("FAIL bad_resp: got tv%b tx%h err%b want tv1 tx3f err1", tx_valid, tx_data, err);
      end
      @(negedge clk);
      n_checks++;
      if (err !== 1'b0) begin
         n_fail++;
         $display("FAIL bad_err_width: got %b want 0", err);
      end
      wait_obs(1, ok);
      n_checks++;
      if (err_cnt - e0 !== 1 || valid_cyc !== v0) begin
         n_fail++;
         $display("FAIL bad_side: got err%0d busv%0d want err1 busv0", err_cnt - e0, valid_cyc - v0);
      end
      exp_q.push_back(8'h4B);
      send_byte(8'h57);
      send_word(32'h0000_0040);
      send_word(32'h0BAD_F00D);
      n_checks++;
      if ({mem_addr, mem_wdata, mem_wstrb} !== {32'h40, 32'h0BADF00D, 4'hF}) begin
         n_fail++;
         $display("FAIL bad_next_req: got a%h d%h s%h want a00000040 d0badf00d sf",
                  mem_addr, mem_wdata, mem_wstrb);
      end
      wait_obs(2, ok);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         a = (obs_q.size() > 0) ? obs_q.pop_front() : 8'hxx;
         n_checks++;
         if (a !== e) begin
            n_fail++;
            $display("FAIL bad_tx: got %h want %h", a, e);
         end
      end
      n_checks++;
      if (bus_cnt - b0 !== 1) begin
         n_fail++;
         $display("FAIL bad_buscnt: got %0d want 1", bus_cnt - b0);
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic test_discard;
      bit ok;
      int b0, e0;
      logic [7:0] e, a;
      wait_cfg  = 2;
      tx_toggle = 1'b1;
      rd_word   = 32'hCAFE_0042;
      b0 = bus_cnt;
      e0 = err_cnt;
      push_word(32'hCAFE_0042);
      send_byte(8'h52);
      send_word(32'h0000_0200);
      send_byte(8'h41);
      send_byte(8'h57);
      send_byte(8'h52);
      send_byte(8'h41);
      send_byte(8'h00);
      wait_obs(4, ok);
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL disc_resp_wait: got %0d bytes want 4", obs_q.size());
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         a = (obs_q.size() > 0) ? obs_q.pop_front() : 8'hxx;
         n_checks++;
         if (a !== e) begin
            n_fail++;
            $display("FAIL disc_tx: got %h want %h", a, e);
         end
      end
      tx_toggle = 1'b0;
      wait_cfg  = 0;
      repeat (3) @(negedge clk);
      exp_q.push_back(8'h4B);
      send_byte(8'h57);
      send_word(32'h0000_0300);
      send_word(32'h0102_0304);
      n_checks++;
      if ({mem_valid, mem_addr, mem_wdata} !== {1'b1, 32'h300, 32'h01020304}) begin
         n_fail++;
         $display("FAIL disc_next_req: got v%b a%h d%h want v1 a00000300 d01020304",
                  mem_valid, mem_addr, mem_wdata);
      end
      wait_obs(1, ok);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         a = (obs_q.size() > 0) ? obs_q.pop_front() : 8'hxx;
         n_checks++;
         if (a !== e) begin
            n_fail++;
            $display("FAIL disc_next_tx: got %h want %h", a, e);
         end
      end
      n_checks++;
      if (bus_cnt - b0 !== 2 || err_cnt !== e0) begin
         n_fail++;
         $display("FAIL disc_side: got bus%0d err%0d want bus2 err0", bus_cnt - b0, err_cnt - e0);
      end
      repeat (4) @(negedge clk);
      n_checks++;
      if (obs_q.size() !== 0) begin
         n_fail++;
         $display("FAIL disc_stray: got %0d extra bytes want 0", obs_q.size());
      end
   endtask

   task automatic test_midreset;
      bit ok;
      logic [7:0] e, a;
      wait_cfg = 1000;
      send_byte(8'h52);
      send_word(32'h0000_0044);
      n_checks++;
      if (mem_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL mr_req: got %b want 1", mem_valid);
      end
      #2;
      resetn = 1'b0;
      #1;
      n_checks++;
      if ({mem_valid, mem_addr, mem_wdata, mem_wstrb, tx_valid, tx_data, busy, err} !== 80'd0) begin
         n_fail++;
         $display("FAIL mr_outputs: got v%b a%h d%h s%h tv%b tx%h b%b e%b want all 0",
                  mem_valid, mem_addr, mem_wdata, mem_wstrb, tx_valid, tx_data, busy, err);
      end
      @(negedge clk);
      resetn   = 1'b1;
      wait_cfg = 0;
      rd_word  = 32'hA5C3_0F96;
      @(negedge clk);
      push_word(32'hA5C3_0F96);
      send_byte(8'h52);
      send_word(32'h0000_0010);
      n_checks++;
      if ({mem_valid, mem_addr, mem_wstrb} !== {1'b1, 32'h10, 4'h0}) begin
         n_fail++;
         $display("FAIL mr_next_req: got v%b a%h s%h want v1 a00000010 s0",
                  mem_valid, mem_addr, mem_wstrb);
      end
      wait_obs(4, ok);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         a = (obs_q.size() > 0) ? obs_q.pop_front() : 8'hxx;
         n_checks++;
         if (a !== e) begin
            n_fail++;
            $display("FAIL mr_tx: got %h want %h", a, e);
         end
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic test_timeout;
      int v0, e0;
`ifdef UART_BUS_MASTER_TIMEOUT_EN
      bit ok;
      logic [7:0] e, a;
`endif
      resp_en = 1'b0;
      v0 = valid_cyc;
      e0 = err_cnt;
`ifdef UART_BUS_MASTER_TIMEOUT_EN
      exp_q.push_back(8'h54);
      send_byte(8'h52);
      send_word(32'h0000_0080);
      wait_obs(1, ok);
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL to_resp_wait: got %0d bytes want 1", obs_q.size());
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         a = (obs_q.size() > 0) ? obs_q.pop_front() : 8'hxx;
         n_checks++;
         if (a !== e) begin
            n_fail++;
            $display("FAIL to_tx: got %h want %h", a, e);
         end
      end
      n_checks++;
      if (valid_cyc - v0 !== 16 || err_cnt - e0 !== 1) begin
         n_fail++;
         $display("FAIL to_tenure: got len%0d err%0d want len16 err1", valid_cyc - v0, err_cnt - e0);
      end
`else
      send_byte(8'h52);
      send_word(32'h0000_0080);
      repeat (10000) @(negedge clk);
      n_checks++;
      if (mem_valid !== 1'b1 || err_cnt !== e0) begin
         n_fail++;
         $display("FAIL to_hold: got v%b err%0d want v1 err0", mem_valid, err_cnt - e0);
      end
      n_checks++;
      if (valid_cyc - v0 < 10000) begin
         n_fail++;
         $display("FAIL to_len: got %0d want >=10000", valid_cyc - v0);
      end
      resetn = 1'b0;
      @(negedge clk);
      resetn = 1'b1;
`endif
      resp_en = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   initial begin
      test_reset;
      test_write;
      test_read;
      test_bad_opcode;
      test_discard;
      test_midreset;
      test_timeout;
      n_checks++;
      if (unstable !== 0 || obs_q.size() !== 0 || exp_q.size() !== 0) begin
         n_fail++;
         $display("FAIL final: got unstable%0d obs%0d exp%0d want 0 0 0",
                  unstable, obs_q.size(), exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
